// File: rtl/lfsr_rng_pkg.sv
// Shared types and helpers for the LFSR random-byte generator.
// Optional build macro LFSR_RNG_PARITY_EN is consumed by lfsr_rng_fifo.
package lfsr_rng_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        S_SEED,
        S_RUN,
        S_IDLE
    } rng_state_t;

    typedef struct packed {
        logic              flush;
        logic              push;
        logic              pop;
        logic [BYTE_W-1:0] data;
    } fifo_req_t;

    // All ones is the XNOR LFSR lockup state; substitute all zeros.
    function automatic logic [63:0] guard_seed(input logic [63:0] seed, input int unsigned width);
        logic [63:0] mask;
        mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return ((seed & mask) == mask) ? 64'd0 : seed;
    endfunction

endpackage

// File: rtl/rng_sync_fifo.sv
// First-word-fall-through byte FIFO with flush; DOUT shows the head entry.
module rng_sync_fifo
    import lfsr_rng_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  fifo_req_t                REQ,
    output logic [BYTE_W-1:0]        DOUT,
    output logic                     EMPTY,
    output logic                     FULL,
    output logic [$clog2(DEPTH):0]   COUNT
);

    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][BYTE_W-1:0] mem;
    logic [AW-1:0]                wr_ptr;
    logic [AW-1:0]                rd_ptr;
    logic [AW:0]                  cnt;
    logic                         do_pop;
    logic                         do_push;

    assign EMPTY   = (cnt == '0);
    assign FULL    = (cnt == (AW+1)'(DEPTH));
    assign COUNT   = cnt;
    assign DOUT    = mem[rd_ptr];
    assign do_pop  = REQ.pop && !EMPTY;
    assign do_push = REQ.push && (!FULL || do_pop);

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (REQ.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= REQ.data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/lfsr_rng_fifo.sv
// Seeds and steps an external XNOR LFSR, packs 8 feedback bits per byte, buffers bytes.
// Define LFSR_RNG_PARITY_EN to sample the XOR of all LFSR bits instead of bit 1.
module lfsr_rng_fifo
    import lfsr_rng_pkg::*;
#(
    parameter int                  NUM_BITS  = 8,
    parameter int                  DEPTH     = 4,
    parameter logic [NUM_BITS-1:0] SEED_INIT = '0
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic                     ENABLE,
    input  logic                     SEED_LOAD,
    input  logic [NUM_BITS-1:0]      SEED,
    input  logic                     RD,
    output logic [BYTE_W-1:0]        DOUT,
    output logic                     EMPTY,
    output logic                     FULL,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic                     LFSR_E,
    output logic                     LFSR_RESET,
    output logic [NUM_BITS-1:0]      LFSR_SEED,
    input  logic [NUM_BITS-1:0]      LFSR_Q
);

    localparam logic [3:0] BITS_PER_BYTE = 4'(BYTE_W);

    rng_state_t          state;
    rng_state_t          state_nxt;
    logic [NUM_BITS-1:0] seed_reg;
    logic [3:0]          issued;
    logic [3:0]          sampled;
    logic                step_d;
    logic [BYTE_W-1:0]   collector;
    logic                lfsr_e;
    logic                lfsr_rst;
    logic                step;
    logic                push;
    logic                sample_bit;
    fifo_req_t           fifo_req;

`ifdef LFSR_RNG_PARITY_EN
    assign sample_bit = ^LFSR_Q;
`else
    logic unused_q_hi;
    assign unused_q_hi = ^LFSR_Q[NUM_BITS-1:1];
    assign sample_bit  = LFSR_Q[0];
`endif

    always_comb begin
        state_nxt = state;
        lfsr_e    = 1'b0;
        lfsr_rst  = 1'b0;
        case (state)
            S_SEED: begin
                lfsr_e    = 1'b1;
                lfsr_rst  = 1'b1;
                state_nxt = ENABLE ? S_RUN : S_IDLE;
            end
            S_RUN: begin
                if (!ENABLE)
                    state_nxt = S_IDLE;
                else if (issued < BITS_PER_BYTE)
                    lfsr_e = 1'b1;
            end
            S_IDLE: begin
                if (ENABLE)
                    state_nxt = S_RUN;
            end
            default: state_nxt = S_SEED;
        endcase
        if (SEED_LOAD)
            state_nxt = S_SEED;
    end

    assign LFSR_E     = RESET_N & lfsr_e;
    assign LFSR_RESET = RESET_N & lfsr_rst;
    assign LFSR_SEED  = seed_reg;
    assign step       = LFSR_E & ~LFSR_RESET;
    // A complete byte may enter a full FIFO only when a pop frees a slot this cycle.
    assign push       = (sampled == BITS_PER_BYTE) && (!FULL || RD) && !SEED_LOAD;

    assign fifo_req = '{flush: SEED_LOAD, push: push, pop: RD && !SEED_LOAD, data: collector};

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state     <= S_SEED;
            seed_reg  <= SEED_INIT;
            issued    <= '0;
            sampled   <= '0;
            step_d    <= 1'b0;
            collector <= '0;
        end else if (SEED_LOAD) begin
            state     <= S_SEED;
            seed_reg  <= NUM_BITS'(guard_seed(64'(SEED), NUM_BITS));
            issued    <= '0;
            sampled   <= '0;
            step_d    <= 1'b0;
            collector <= '0;
        end else begin
            state  <= state_nxt;
            step_d <= step;
            if (push) begin
                issued  <= '0;
                sampled <= '0;
            end else begin
                if (step)
                    issued <= issued + 4'd1;
                if (step_d) begin
                    collector <= {collector[BYTE_W-2:0], sample_bit};
                    sampled   <= sampled + 4'd1;
                end
            end
        end
    end

    rng_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .REQ     (fifo_req),
        .DOUT    (DOUT),
        .EMPTY   (EMPTY),
        .FULL    (FULL),
        .COUNT   (COUNT)
    );

endmodule

// File: tb/tb_lfsr_rng_fifo.sv
// Bench for lfsr_rng_fifo with an attached 8-bit XNOR LFSR and a byte-stream reference model.
module tb_lfsr_rng_fifo;

    localparam int NB    = 8;
    localparam int DEPTH = 4;

    logic          CLK       = 1'b0;
    logic          RESET_N   = 1'b0;
    logic          ENABLE    = 1'b1;
    logic          SEED_LOAD = 1'b0;
    logic [NB-1:0] SEED      = '0;
    logic          RD        = 1'b0;
    logic [7:0]    DOUT;
    logic          EMPTY;
    logic          FULL;
    logic [2:0]    COUNT;
    logic          LFSR_E;
    logic          LFSR_RESET;
    logic [NB-1:0] LFSR_SEED;
    logic [NB-1:0] LFSR_Q    = '0;

    int         checks = 0;
    int         passed = 0;
    int         steps  = 0;
    logic [7:0] mstate = '0;

    always #5 CLK = ~CLK;

    lfsr_rng_fifo #(.NUM_BITS(NB), .DEPTH(DEPTH), .SEED_INIT(8'h00)) dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .ENABLE     (ENABLE),
        .SEED_LOAD  (SEED_LOAD),
        .SEED       (SEED),
        .RD         (RD),
        .DOUT       (DOUT),
        .EMPTY      (EMPTY),
        .FULL       (FULL),
        .COUNT      (COUNT),
        .LFSR_E     (LFSR_E),
        .LFSR_RESET (LFSR_RESET),
        .LFSR_SEED  (LFSR_SEED),
        .LFSR_Q     (LFSR_Q)
    );

    // 8-bit XNOR Fibonacci LFSR, taps 8,6,5,4, new bit enters at Q[1].
    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], ~(s[7] ^ s[5] ^ s[4] ^ s[3])};
    endfunction

    always @(posedge CLK)
        if (LFSR_E) LFSR_Q <= LFSR_RESET ? LFSR_SEED : lfsr_step(LFSR_Q);

    always @(negedge CLK)
        if (LFSR_E && !LFSR_RESET) steps++;

    task automatic model_seed(input logic [7:0] s);
        mstate = (s == 8'hFF) ? 8'h00 : s;
    endtask

    task automatic model_next(output logic [7:0] b);
        b = '0;
        for (int i = 0; i < 8; i++) begin
            mstate = lfsr_step(mstate);
`ifdef LFSR_RNG_PARITY_EN
            b = {b[6:0], ^mstate};
`else
            b = {b[6:0], mstate[0]};
`endif
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge CLK); #1; end
    endtask

    task automatic reseed(input logic [7:0] s);
        SEED_LOAD = 1'b1; SEED = s;
        tick(1);
        SEED_LOAD = 1'b0;
        model_seed(s);
    endtask

    task automatic do_pop(output logic [7:0] d, output bit ok);
        int n = 0;
        ok = 1'b0; d = '0;
        while (EMPTY && n < 40) begin tick(1); n++; end
        if (!EMPTY) begin
            ok = 1'b1; d = DOUT; RD = 1'b1;
            tick(1);
            RD = 1'b0;
        end
    endtask

    task automatic test_reset;
        RESET_N = 1'b0; RD = 1'b1;
        tick(3);
        @(negedge CLK);
        checks++; if (COUNT !== 3'd0 || EMPTY !== 1'b1 || FULL !== 1'b0)
            $display("FAIL reset_flags: COUNT=%0d EMPTY=%b FULL=%b want 0/1/0", COUNT, EMPTY, FULL); else passed++;
        checks++; if (DOUT !== 8'h00) $display("FAIL reset_dout: got %h want 00", DOUT); else passed++;
        checks++; if (LFSR_E !== 1'b0 || LFSR_RESET !== 1'b0)
            $display("FAIL reset_lfsr_ctl: E=%b RESET=%b want 0/0", LFSR_E, LFSR_RESET); else passed++;
        @(posedge CLK); #1;
        RD = 1'b0;
    endtask

    task automatic test_first_byte;
        int n = 0;
        logic [7:0] e, d;
        bit ok;
        RESET_N = 1'b1;
        model_seed(8'h00);
        @(negedge CLK);
        checks++; if (LFSR_E !== 1'b1 || LFSR_RESET !== 1'b1 || LFSR_SEED !== 8'h00)
            $display("FAIL seed_cycle: E=%b RESET=%b SEED=%h want 1/1/00", LFSR_E, LFSR_RESET, LFSR_SEED); else passed++;
        while (EMPTY && n < 40) begin @(posedge CLK); #1; n++; end
        checks++; if (n !== 11) $display("FAIL first_latency: got %0d cycles want 11", n); else passed++;
        checks++; if (DOUT !== 8'hF4) $display("FAIL first_byte: got %h want f4", DOUT); else passed++;
        do_pop(d, ok);
        model_next(e);
        for (int i = 0; i < 2; i++) begin
            do_pop(d, ok); model_next(e);
            checks++; if (!ok || d !== e) $display("FAIL stream_byte%0d: got %h ok=%b want %h", i, d, ok, e); else passed++;
        end
    endtask

    task automatic test_seed_load;
        logic [7:0] e, d;
        bit ok;
        tick(30);
        RD = 1'b1;
        reseed(8'hFF);
        RD = 1'b0;
        checks++; if (EMPTY !== 1'b1 || COUNT !== 3'd0)
            $display("FAIL seed_flush: EMPTY=%b COUNT=%0d want 1/0", EMPTY, COUNT); else passed++;
        checks++; if (LFSR_SEED !== 8'h00 || LFSR_RESET !== 1'b1)
            $display("FAIL seed_guard: SEED=%h RESET=%b want 00/1", LFSR_SEED, LFSR_RESET); else passed++;
        do_pop(d, ok); model_next(e);
        checks++; if (!ok || d !== 8'hF4) $display("FAIL reseed_first: got %h ok=%b want f4", d, ok); else passed++;
        do_pop(d, ok); model_next(e);
        checks++; if (!ok || d !== e) $display("FAIL reseed_second: got %h ok=%b want %h", d, ok, e); else passed++;
    endtask

    task automatic test_full_stall;
        logic [7:0] e, d;
        bit ok;
        int s0, n;
        reseed(8'($urandom_range(0, 254)));
        tick(80);
        checks++; if (FULL !== 1'b1 || COUNT !== 3'd4) $display("FAIL full: FULL=%b COUNT=%0d want 1/4", FULL, COUNT); else passed++;
        s0 = steps;
        tick(20);
        checks++; if (steps !== s0) $display("FAIL stall_steps: got %0d steps want 0", steps - s0); else passed++;
        do_pop(d, ok); model_next(e);
        checks++; if (!ok || d !== e) $display("FAIL stall_byte1: got %h want %h", d, e); else passed++;
        checks++; if (COUNT !== 3'd4) $display("FAIL pushpop_count: got %0d want 4", COUNT); else passed++;
        do_pop(d, ok); model_next(e);
        checks++; if (!ok || d !== e) $display("FAIL stall_byte2: got %h want %h", d, e); else passed++;
        checks++; if (COUNT !== 3'd3) $display("FAIL pop_count: got %0d want 3", COUNT); else passed++;
        n = 0;
        while (COUNT != 3'd4 && n < 40) begin tick(1); n++; end
        checks++; if (n !== 9) $display("FAIL refill_latency: got %0d want 9", n); else passed++;
        for (int i = 3; i <= 5; i++) begin
            do_pop(d, ok); model_next(e);
            checks++; if (!ok || d !== e) $display("FAIL stall_byte%0d: got %h want %h", i, d, e); else passed++;
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] e;
        int pops = 0;
        tick(80);
        checks++; if (FULL !== 1'b1) $display("FAIL b2b_full: got %b want 1", FULL); else passed++;
        RD = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK);
            if (!EMPTY) begin
                model_next(e); pops++;
                checks++; if (DOUT !== e) $display("FAIL b2b_byte%0d: got %h want %h", pops, DOUT, e); else passed++;
            end
            @(posedge CLK); #1;
            if (i == 0) begin
                checks++; if (COUNT !== 3'd4) $display("FAIL b2b_count: got %0d want 4", COUNT); else passed++;
            end
        end
        RD = 1'b0;
        checks++; if (pops < 7) $display("FAIL b2b_pops: got %0d want >=7", pops); else passed++;
    endtask

    task automatic test_pause;
        logic [7:0] e, d;
        bit ok;
        int base, n = 0;
        reseed(8'($urandom_range(0, 255)));
        base = steps;
        while (steps - base < 3 && n < 30) begin tick(1); n++; end
        ENABLE = 1'b0;
        tick(20);
        checks++; if (steps - base !== 3 || EMPTY !== 1'b1)
            $display("FAIL pause_hold: got %0d steps EMPTY=%b want 3/1", steps - base, EMPTY); else passed++;
        ENABLE = 1'b1;
        n = 0;
        while (EMPTY && n < 40) begin tick(1); n++; end
        checks++; if (steps - base !== 8) $display("FAIL pause_steps: got %0d want 8", steps - base); else passed++;
        do_pop(d, ok); model_next(e);
        checks++; if (!ok || d !== e) $display("FAIL pause_byte: got %h want %h", d, e); else passed++;
    endtask

    task automatic test_random;
        logic [7:0] e;
        reseed(8'($urandom_range(0, 255)));
        for (int i = 0; i < 400; i++) begin
            RD     = ($urandom_range(0, 7) == 0);
            ENABLE = ($urandom_range(0, 5) != 0);
            @(negedge CLK);
            if (RD && !EMPTY) begin
                model_next(e);
                checks++; if (DOUT !== e) $display("FAIL rand_byte@%0d: got %h want %h", i, DOUT, e); else passed++;
            end
            @(posedge CLK); #1;
        end
        RD = 1'b0; ENABLE = 1'b1;
    endtask

    task automatic test_reset_mid;
        logic [7:0] e, d;
        bit ok;
        reseed(8'($urandom_range(0, 255)));
        RD = 1'b1;
        tick(1);
        RD = 1'b0;
        checks++; if (EMPTY !== 1'b1 || COUNT !== 3'd0)
            $display("FAIL rd_empty: EMPTY=%b COUNT=%0d want 1/0", EMPTY, COUNT); else passed++;
        tick(3);
        RESET_N = 1'b0; RD = 1'b1;
        tick(2);
        @(negedge CLK);
        checks++; if (COUNT !== 3'd0 || EMPTY !== 1'b1 || DOUT !== 8'h00 || LFSR_E !== 1'b0)
            $display("FAIL mid_reset: COUNT=%0d EMPTY=%b DOUT=%h E=%b want 0/1/00/0", COUNT, EMPTY, DOUT, LFSR_E); else passed++;
        @(posedge CLK); #1;
        RD = 1'b0; RESET_N = 1'b1;
        model_seed(8'h00);
        do_pop(d, ok); model_next(e);
        checks++; if (!ok || d !== 8'hF4) $display("FAIL restart_first: got %h want f4", d); else passed++;
        do_pop(d, ok); model_next(e);
        checks++; if (!ok || d !== e) $display("FAIL restart_second: got %h want %h", d, e); else passed++;
    endtask

    initial begin
        test_reset();
        test_first_byte();
        test_seed_load();
        test_full_stall();
        test_back_to_back();
        test_pause();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
